// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// The extended width W and the iteration count K are derived here from the operand width N.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  localparam int DEFAULT_N = 64;

  // Operands carry two extra bits so unsigned values stay non-negative under Booth recoding.
  function automatic int calc_w(input int n);
    return n + 2;
  endfunction

  function automatic int calc_k(input int n);
    return n / 2 + 1;
  endfunction

  function automatic booth_digit_e booth_recode(input logic [2:0] triplet);
    booth_digit_e digit;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Operand-issue and result handshake bundle for booth_radix4_multiplier.
// The issue stage uses the master view; the multiplier uses the slave view.
interface booth_radix4_multiplier_if #(
  parameter int N = 64
);

  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [N-1:0]     multiplicand;
  logic [N-1:0]     multiplier;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   product;

  modport master (
    output in_valid,
    output is_signed,
    output multiplicand,
    output multiplier,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  is_signed,
    input  multiplicand,
    input  multiplier,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/booth_radix4_multiplier_recoder.sv
// Radix-4 Booth recoder: turns a multiplier triplet and the extended multiplicand
// into the signed addend (0, +-M, +-2M) for one iteration.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int ACC_W = 68
) (
  input  logic [2:0]       triplet,
  input  logic [ACC_W-1:0] m,
  output logic [ACC_W-1:0] addend
);

  booth_digit_e     digit;
  logic [ACC_W-1:0] mag;
  logic             invert;

  // Negation is ~mag + 1; the +1 enters as a carry-in on the final add.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the case,
    // otherwise an unlisted branch would hold its old value and infer a latch.
    digit  = booth_recode(triplet);
    mag    = '0;
    invert = 1'b0;
    case (digit)
      POS1: mag = m;
      POS2: mag = {m[ACC_W-2:0], 1'b0};
      NEG1: begin
        mag    = m;
        invert = 1'b1;
      end
      NEG2: begin
        mag    = {m[ACC_W-2:0], 1'b0};
        invert = 1'b1;
      end
      default: ;
    endcase
    addend = (invert ? ~mag : mag) + ACC_W'(invert);
  end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per cycle and
// returns the exact 2N-bit product for signed or unsigned operands.
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  booth_radix4_multiplier_if.slave bus
);

  localparam int W     = calc_w(N);
  localparam int ACC_W = W + 2;
  localparam int K     = calc_k(N);
  localparam int CNT_W = $clog2(K + 1);
  localparam int SHR_W = ACC_W + W + 1;

  state_e                   state;
  state_e                   next_state;
  logic                     rdy_en;
  logic [CNT_W-1:0]         cnt;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         m;
  logic [W-1:0]             q;
  logic                     q_m1;
  logic [2*N-1:0]           product_r;

  logic                     accept;
  logic                     iterate;
  logic                     last_iter;
  logic                     ext_a;
  logic                     ext_b;
  logic [ACC_W-1:0]         addend;
  logic [ACC_W-1:0]         acc_sum;
  logic signed [SHR_W-1:0]  shr_in;
  logic signed [SHR_W-1:0]  shr_out;

  // Handshake outputs come from registered state only.
  assign bus.in_ready  = (state == IDLE) && rdy_en;
  assign bus.out_valid = (state == DONE);
  assign bus.product   = product_r;

  assign accept    = bus.in_valid && (state == IDLE) && rdy_en;
  assign iterate   = (state == RUN);
  assign last_iter = iterate && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops are written with <= so every register samples pre-edge values
    // regardless of the order in which the always blocks are evaluated.
    if (!rst_n) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= next_state;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last_iter) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(K);
    end else if (iterate) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Extension bits: copies of the sign in signed mode, zeros otherwise.
  assign ext_a = bus.is_signed & bus.multiplicand[N-1];
  assign ext_b = bus.is_signed & bus.multiplier[N-1];

  booth_r4_recoder #(
    .ACC_W(ACC_W)
  ) u_recoder (
    .triplet({q[1:0], q_m1}),
    .m      (m),
    .addend (addend)
  );

  // One iteration: add the recoded digit, then shift {acc, Q, q-1} right by two, keeping sign.
  assign acc_sum = acc + addend;
  assign shr_in  = {acc_sum, q, q_m1};
  assign shr_out = shr_in >>> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath flops are reset as well; an abort must leave no trace of
    // the old operands and the product must read zero while in reset.
    if (!rst_n) begin
      acc  <= '0;
      m    <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
    end else if (accept) begin
      acc  <= '0;
      m    <= {{(ACC_W - N){ext_a}}, bus.multiplicand};
      q    <= {{(W - N){ext_b}}, bus.multiplier};
      q_m1 <= 1'b0;
    end else if (iterate) begin
      acc  <= shr_out[SHR_W-1 -: ACC_W];
      q    <= shr_out[W:1];
      q_m1 <= shr_out[0];
    end
  end

  // The result register only loads on the final iteration, so it holds across handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= '0;
    end else if (last_iter) begin
      product_r <= shr_out[2*N:1];
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier: directed corners, timing,
// back-pressure, abort by reset, and a randomised run against a 2N-bit reference.
module tb_booth_radix4_multiplier;

  localparam int N = 64;
  localparam int K = N / 2 + 1;

  typedef logic [N-1:0]   op_t;
  typedef logic [2*N-1:0] prod_t;

  logic clk = 1'b0;
  logic rst_n;

  booth_radix4_multiplier_if #(.N(N)) bus ();

  booth_radix4_multiplier #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  prod_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input prod_t obs, input prod_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic prod_t ref_mul(input op_t a, input op_t b, input logic s);
    logic signed [2*N-1:0] sa;
    logic signed [2*N-1:0] sb_v;
    logic [2*N-1:0]        ua;
    logic [2*N-1:0]        ub;
    if (s) begin
      sa   = {{N{a[N-1]}}, a};
      sb_v = {{N{b[N-1]}}, b};
      return prod_t'(sa * sb_v);
    end
    ua = {{N{1'b0}}, a};
    ub = {{N{1'b0}}, b};
    return ua * ub;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge with its cycle stamp.
  task automatic issue(input op_t a, input op_t b, input logic s, input prod_t exp,
                       output int stamp);
    int budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check_bit("in_ready_wait", bus.in_ready, 1'b1);
    bus.in_valid     = 1'b1;
    bus.is_signed    = s;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    sb.push_back(exp);
    @(negedge clk);
    stamp            = cyc;
    bus.in_valid     = 1'b0;
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
    bus.is_signed    = 1'($urandom_range(0, 1));
    check_bit("in_ready_busy", bus.in_ready, 1'b0);
  endtask

  task automatic wait_out(output int seen);
    int budget = 0;
    while (bus.out_valid !== 1'b1 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    check_bit("out_valid_wait", bus.out_valid, 1'b1);
    seen = cyc;
  endtask

  // Pops the scoreboard, compares, optionally stalls (optionally offering new operands), then handshakes.
  task automatic finish_op(input string tag, input int stall, input logic offer);
    prod_t exp;
    prod_t held;
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    check(tag, bus.product, exp);
    held = bus.product;
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      if (offer) begin
        bus.in_valid     = 1'b1;
        bus.multiplicand = {$urandom, $urandom};
        bus.multiplier   = {$urandom, $urandom};
      end
      @(negedge clk);
      check("stall_product", bus.product, held);
      check_bit("stall_out_valid", bus.out_valid, 1'b1);
      check_bit("stall_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_bit("post_hs_out_valid", bus.out_valid, 1'b0);
    check_bit("post_hs_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic quiet_window(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    check(tag, prod_t'(seen), prod_t'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c0;
    int   c1;
    int   t;
    op_t  a;
    op_t  b;
    logic s;

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.is_signed    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      check_bit("rst_in_ready", bus.in_ready, 1'b0);
      check_bit("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_product", bus.product, '0);
    end
    rst_n = 1'b1;
    #1;
    check_bit("in_ready_before_edge", bus.in_ready, 1'b0);
    @(negedge clk);
    check_bit("in_ready_after_release", bus.in_ready, 1'b1);

    // Signed -1 x -1, latency and initiation interval with out_ready held high.
    bus.out_ready = 1'b1;
    issue('1, '1, 1'b1, prod_t'(1), c0);
    wait_out(t);
    check("latency", prod_t'(t - c0), prod_t'(K));
    finish_op("signed_m1_m1", 0, 1'b0);
    issue('1, '1, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, c1);
    check("initiation_interval", prod_t'(c1 - c0), prod_t'(K + 2));
    wait_out(t);
    finish_op("unsigned_max_max", 0, 1'b0);

    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
          128'h4000_0000_0000_0000_0000_0000_0000_0000, c0);
    wait_out(t);
    finish_op("signed_min_min", 0, 1'b0);

    issue(64'h7FFF_FFFF_FFFF_FFFF, '1, 1'b1,
          128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001, c0);
    wait_out(t);
    finish_op("signed_max_m1", 0, 1'b0);

    // Back-pressure: ten stalled cycles in DONE while new operands are offered and ignored.
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'hFEDC_BA98_7654_3210;
    issue(a, b, 1'b0, ref_mul(a, b, 1'b0), c0);
    wait_out(t);
    finish_op("backpressure", 10, 1'b1);
    quiet_window("no_result_after_bp", 2 * K);

    // Abort by reset ten cycles into RUN.
    a = 64'hDEAD_BEEF_0000_0001;
    b = 64'h0000_0000_CAFE_F00D;
    issue(a, b, 1'b1, ref_mul(a, b, 1'b1), c0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_bit("abort_out_valid", bus.out_valid, 1'b0);
    check_bit("abort_in_ready", bus.in_ready, 1'b0);
    check("abort_product", bus.product, '0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("no_result_after_abort", 2 * K);

    issue(64'd11, 64'd14, 1'b1, prod_t'(154), c0);
    wait_out(t);
    finish_op("after_abort_11x14", 0, 1'b0);

    // Random operands, random mode, random stalls and issue gaps.
    for (int i = 0; i < 500; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       a = '1;
        1:       b = 64'h8000_0000_0000_0000;
        2:       a = '0;
        3:       b = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, b, s, ref_mul(a, b, s), c0);
      wait_out(t);
      finish_op("random", $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
